fifo_stream_reader: RTL and testbench

Read-side master for the registered-boundary FIFO wrapper. It issues `rdreq` pops against the FIFO's delayed status, captures the returned words after a fixed round-trip latency into a small local skid buffer, and presents them as a valid/ready stream. It sits between the FIFO wrapper outputs and any downstream consumer. It keeps full throughput while never over-reading the FIFO and never overflowing its own buffer.

---
 rtl/fifo_stream_reader.sv | 98 +++++++++
 tb/tb_fifo_stream_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for a registered-boundary FIFO: credit-limited pops, fixed-latency capture into a
// skid buffer, valid/ready output. Optional transfer counter enabled by FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader #(
   parameter int DWIDTH    = 16,
   parameter int UWIDTH    = 5,
   parameter int LATENCY   = 2,
   parameter int BUF_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              srst_n_i,
   input  logic [DWIDTH-1:0] q_i,
   input  logic [UWIDTH-1:0] usedw_i,
   output logic              rdreq_o,
   output logic [DWIDTH-1:0] m_data_o,
   output logic              m_valid_o,
`ifdef FIFO_STREAM_READER_STATS_EN
   output logic [31:0]       words_cnt_o,
`endif
   input  logic              m_ready_i
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int KW = ((UWIDTH > CW) ? UWIDTH : CW) + 1;

   logic [LATENCY-1:0] pend_q, pend_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      buf_cnt_q, buf_cnt_d;
   logic [DWIDTH-1:0]  mem_q [BUF_DEPTH];
   logic [CW-1:0]      inflight;
   logic               issue;
   logic               capture;
   logic               xfer;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + CW'(pend_q[i]);
      end
   end

   // Credit counts words already buffered plus words still travelling back from the FIFO.
   assign issue   = (KW'(usedw_i) > KW'(inflight)) &&
                    ((KW'(buf_cnt_q) + KW'(inflight)) < KW'(BUF_DEPTH));
   assign rdreq_o = srst_n_i && issue;

   assign capture   = pend_q[LATENCY-1];
   assign m_valid_o = (buf_cnt_q != '0);
   assign xfer      = m_valid_o && m_ready_i;
   assign m_data_o  = m_valid_o ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      pend_d    = (pend_q << 1) | LATENCY'(rdreq_o);
      wr_ptr_d  = wr_ptr_q + PW'(capture);
      rd_ptr_d  = rd_ptr_q + PW'(xfer);
      buf_cnt_d = buf_cnt_q + CW'(capture) - CW'(xfer);
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         pend_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         buf_cnt_q <= '0;
      end else begin
         pend_q    <= pend_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         buf_cnt_q <= buf_cnt_d;
      end
   end

   // Buffer storage is left unreset; the output mux hides stale contents while empty.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         mem_q[wr_ptr_q] <= q_i;
      end
   end

`ifdef FIFO_STREAM_READER_STATS_EN
   logic [31:0] words_cnt_q, words_cnt_d;

   always_comb begin
      words_cnt_d = words_cnt_q + 32'(xfer);
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         words_cnt_q <= '0;
      end else begin
         words_cnt_q <= words_cnt_d;
      end
   end

   assign words_cnt_o = words_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: queue-based FIFO model with delayed q/usedw, monitor
// checks stream order, hold rules, credit bound and latencies.
`timescale 1ns/1ps
module tb_fifo_stream_reader;
   localparam int DW  = 16;
   localparam int UW  = 5;
   localparam int LAT = 2;
   localparam int BD  = 4;

   logic          clk_i = 1'b0;
   logic          srst_n_i = 1'b0;
   logic [DW-1:0] q_i = '0;
   logic [UW-1:0] usedw_i = '0;
   logic          rdreq_o;
   logic [DW-1:0] m_data_o;
   logic          m_valid_o;
   logic          m_ready_i = 1'b0;
`ifdef FIFO_STREAM_READER_STATS_EN
   logic [31:0]   words_cnt_o;
   int            words_exp = 0;
`endif

   fifo_stream_reader #(.DWIDTH(DW), .UWIDTH(UW), .LATENCY(LAT), .BUF_DEPTH(BD)) dut (
      .clk_i     (clk_i),
      .srst_n_i  (srst_n_i),
      .q_i       (q_i),
      .usedw_i   (usedw_i),
      .rdreq_o   (rdreq_o),
      .m_data_o  (m_data_o),
      .m_valid_o (m_valid_o),
`ifdef FIFO_STREAM_READER_STATS_EN
      .words_cnt_o (words_cnt_o),
`endif
      .m_ready_i (m_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int            checks = 0;
   int            failures = 0;
   logic [DW-1:0] fifo[$];
   logic [DW-1:0] exp_q[$];
   int            hist[LAT+1];
   logic [DW-1:0] pipe[LAT];
   int            ready_mode = 0;
   bit            rst_req = 1'b1;
   int            pops = 0;
   int            xfers = 0;
   int            cyc = 0;
   int            first_xfer = -1;
   int            outstanding = 0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   bit            rst_seen = 1'b0;
   logic [DW-1:0] e;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // FIFO model: pops seen in cycle t appear on q_i in cycle t+LAT; usedw_i is the fill level LAT cycles ago.
   initial begin : fifo_model
      bit rd_s, rst_s;
      logic [DW-1:0] w;
      forever begin
         @(negedge clk_i);
         rd_s  = rdreq_o;
         rst_s = srst_n_i;
         @(posedge clk_i);
         #1;
         w = DW'($urandom);
         if (rd_s && rst_s) begin
            pops++;
            chk(fifo.size() != 0, "fifo_underflow", fifo.size(), 1);
            if (fifo.size() != 0) w = fifo.pop_front();
         end
         for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0] = w;
         for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = fifo.size();
         if (rst_req && srst_n_i) begin
            fifo.delete();
            exp_q.delete();
            for (int k = 0; k <= LAT; k++) hist[k] = 0;
         end
         srst_n_i = !rst_req;
         q_i      = pipe[LAT-1];
         usedw_i  = UW'(hist[LAT]);
         case (ready_mode)
            1:       m_ready_i = 1'b1;
            2:       m_ready_i = 1'($urandom_range(0, 1));
            default: m_ready_i = 1'b0;
         endcase
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk_i);
         if (!srst_n_i) begin
            chk(rdreq_o == 1'b0, "rst_rdreq", rdreq_o, 0);
            if (rst_seen) chk(m_valid_o == 1'b0, "rst_valid", m_valid_o, 0);
            rst_seen    = 1'b1;
            outstanding = 0;
`ifdef FIFO_STREAM_READER_STATS_EN
            words_exp = 0;
`endif
         end else begin
            rst_seen = 1'b0;
            if (prev_stall) begin
               chk(m_valid_o == 1'b1, "hold_valid", m_valid_o, 1);
               chk(m_data_o == prev_data, "hold_data", m_data_o, prev_data);
            end
            if (!m_valid_o) chk(m_data_o == '0, "idle_data", m_data_o, 0);
            if (rdreq_o) outstanding++;
            if (m_valid_o && m_ready_i) begin
               xfers++;
               if (first_xfer < 0) first_xfer = cyc;
               chk(exp_q.size() != 0, "unexpected_word", m_data_o, 0);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk(m_data_o == e, "data_order", m_data_o, e);
               end
               outstanding--;
`ifdef FIFO_STREAM_READER_STATS_EN
               words_exp++;
`endif
            end
            chk(outstanding <= BD, "credit_bound", outstanding, BD);
`ifdef FIFO_STREAM_READER_STATS_EN
            chk(words_cnt_o == 32'(words_exp), "words_cnt", words_cnt_o, words_exp);
`endif
         end
         prev_stall = srst_n_i && m_valid_o && !m_ready_i;
         prev_data  = m_data_o;
      end
   end

   task automatic write_words(input int n, input logic [DW-1:0] base, input bit rnd, output int wcyc);
      logic [DW-1:0] v;
      @(negedge clk_i);
      wcyc = cyc;
      for (int i = 0; i < n; i++) begin
         v = rnd ? DW'($urandom) : base + DW'(i);
         fifo.push_back(v);
         exp_q.push_back(v);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || fifo.size() != 0) && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      chk(n < 500, "drain_timeout", n, 500);
      repeat (LAT + 4) @(negedge clk_i);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int w, p0, x0;
      for (int k = 0; k < LAT; k++) pipe[k] = '0;
      for (int k = 0; k <= LAT; k++) hist[k] = 5;
      usedw_i = 5'd5;
      for (int i = 0; i < 5; i++) begin
         fifo.push_back(DW'(16'h0101 + i));
         exp_q.push_back(DW'(16'h0101 + i));
      end

      // reset with a non-empty FIFO, then release
      repeat (3) @(negedge clk_i);
      rst_req = 1'b0;
      @(negedge clk_i);
      chk(rdreq_o == 1'b1, "release_rdreq", rdreq_o, 1);
      x0 = xfers;
      ready_mode = 1;
      wait_drain();
      chk(xfers - x0 == 5, "reset_drain_count", xfers - x0, 5);

      // streaming drain of 10 words
      p0 = pops; x0 = xfers; first_xfer = -1;
      write_words(10, 16'h0001, 1'b0, w);
      wait_drain();
      chk(pops - p0 == 10, "stream_pops", pops - p0, 10);
      chk(xfers - x0 == 10, "stream_xfers", xfers - x0, 10);
      chk(first_xfer - w == LAT + 4, "stream_first_lat", first_xfer - w, LAT + 4);

      // backpressure: only BD words may be popped
      ready_mode = 0;
      p0 = pops; x0 = xfers;
      write_words(8, 16'h0011, 1'b0, w);
      repeat (20) @(negedge clk_i);
      chk(pops - p0 == BD, "bp_pops", pops - p0, BD);
      chk(m_valid_o == 1'b1, "bp_valid", m_valid_o, 1);
      chk(m_data_o == 16'h0011, "bp_data", m_data_o, 16'h0011);
      ready_mode = 1;
      wait_drain();
      chk(xfers - x0 == 8, "bp_xfers", xfers - x0, 8);
      chk(pops - p0 == 8, "bp_total_pops", pops - p0, 8);

      // single word, stale usedw must not cause a second pop
      p0 = pops; x0 = xfers; first_xfer = -1;
      write_words(1, 16'hBEEF, 1'b0, w);
      repeat (15) @(negedge clk_i);
      chk(pops - p0 == 1, "single_pops", pops - p0, 1);
      chk(xfers - x0 == 1, "single_xfers", xfers - x0, 1);
      chk(first_xfer - w == LAT + 4, "single_lat", first_xfer - w, LAT + 4);

      // random data and random ready, pointers wrap many times
      ready_mode = 2;
      x0 = xfers;
      for (int i = 0; i < 20; i++) begin
         write_words(1, '0, 1'b1, w);
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
      end
      wait_drain();
      chk(xfers - x0 == 20, "random_xfers", xfers - x0, 20);

      // mid-stream reset with words buffered and in flight
      ready_mode = 0;
      write_words(8, 16'h0021, 1'b0, w);
      repeat (5) @(negedge clk_i);
      rst_req = 1'b1;
      repeat (2) @(negedge clk_i);
      chk(m_valid_o == 1'b0, "mrst_valid", m_valid_o, 0);
      rst_req = 1'b0;
      @(negedge clk_i);
`ifdef FIFO_STREAM_READER_STATS_EN
      chk(words_cnt_o == 32'd0, "mrst_words_cnt", words_cnt_o, 0);
`endif
      chk(m_valid_o == 1'b0, "mrst_post_valid", m_valid_o, 0);
      ready_mode = 1;
      x0 = xfers;
      write_words(3, 16'h0A01, 1'b0, w);
      wait_drain();
      chk(xfers - x0 == 3, "mrst_fresh_xfers", xfers - x0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
